// File: rtl/rle_pkg.sv
// ---------------------------------------------------------------------------
// rle_pkg
//
// Shared definitions for the JPEG AC run/level symbol serializer:
//   - width constants for the merged coefficient group and the zero counter
//   - the serializer state enumeration
//   - accessors that split a packed entry {run[5:0], level[7:0]}
//   - the fixed run/level encodings of the ZRL and EOB symbols
// ---------------------------------------------------------------------------
package rle_pkg;

    // Geometry of one merged 16-coefficient group.
    localparam int N_ENTRY   = 16;
    localparam int ENTRY_W   = 14;
    localparam int LEVEL_W   = 8;
    localparam int RUN_W     = ENTRY_W - LEVEL_W;
    localparam int ARRAY_W   = N_ENTRY * ENTRY_W;

    // A block holds at most 64 coefficients, so 7 bits cover every zero count.
    localparam int ACC_W     = 7;

    // Symbol run field is a single nibble.
    localparam int SYM_RUN_W = 4;

    // Serializer control states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1,
        EOB  = 2'd2
    } state_e;

    // ZRL stands for sixteen zeros: run 15 followed by an implicit zero level.
    localparam logic [SYM_RUN_W-1:0] ZRL_RUN   = 4'd15;
    localparam logic [LEVEL_W-1:0]   ZRL_LEVEL = 8'd0;
    localparam logic [ACC_W-1:0]     ZRL_SPAN  = 7'd16;

    // EOB is the all-zero run/level pair.
    localparam logic [SYM_RUN_W-1:0] EOB_RUN   = 4'd0;
    localparam logic [LEVEL_W-1:0]   EOB_LEVEL = 8'd0;

    // Zero run preceding the entry's nonzero level.
    function automatic logic [RUN_W-1:0] entryRun(input logic [ENTRY_W-1:0] entry);
        return entry[ENTRY_W-1 -: RUN_W];
    endfunction

    // Nonzero level carried by the entry.
    function automatic logic [LEVEL_W-1:0] entryLevel(input logic [ENTRY_W-1:0] entry);
        return entry[LEVEL_W-1:0];
    endfunction

endpackage

// File: rtl/rle_symbol_serializer.sv
// ---------------------------------------------------------------------------
// rle_symbol_serializer
//
// Turns merged 16-coefficient groups into JPEG-style AC run/level symbols,
// one symbol per cycle. Zero runs longer than 15 are broken up with ZRL
// symbols, zeros are carried from one group into the next, and a block that
// finishes in zeros is closed with a single EOB.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   in_valid / in_ready     group handshake (ready only while idle)
//   in_last                 group closes the current block
//   in_left / in_right      leading / trailing zeros of the group
//   in_flag                 0 = group is entirely zero
//   in_array                16 x {run, level}; entry in_size-1 comes first
//   in_size                 number of valid entries (0..16)
//   sym_valid / sym_ready   symbol handshake
//   sym_run, sym_level      run/level of the symbol
//   sym_zrl, sym_eob        symbol is a ZRL / EOB marker
//   sym_last                final symbol of the block
// ---------------------------------------------------------------------------
module rle_symbol_serializer
    import rle_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_last,
    input  logic [3:0]           in_left,
    input  logic [3:0]           in_right,
    input  logic                 in_flag,
    input  logic [ARRAY_W-1:0]   in_array,
    input  logic [4:0]           in_size,
    output logic                 sym_valid,
    input  logic                 sym_ready,
    output logic [SYM_RUN_W-1:0] sym_run,
    output logic [LEVEL_W-1:0]   sym_level,
    output logic                 sym_zrl,
    output logic                 sym_eob,
    output logic                 sym_last
);

    state_e               state_q, state_d;
    logic [ACC_W-1:0]     acc_q, acc_d;
    logic [ACC_W-1:0]     pendRun_q, pendRun_d;
    logic [3:0]           idx_q, idx_d;
    logic [ARRAY_W-1:0]   array_q, array_d;
    logic [3:0]           right_q, right_d;
    logic                 last_q, last_d;

    logic                 accept;
    logic                 handshake;
    logic [ACC_W-1:0]     accNext;
    logic [3:0]           firstIdx;
    logic [3:0]           prevIdx;

    logic                 symValid_d;
    logic [SYM_RUN_W-1:0] symRun_d;
    logic [LEVEL_W-1:0]   symLevel_d;
    logic                 symZrl_d;
    logic                 symEob_d;
    logic                 symLast_d;

    assign in_ready  = (state_q == IDLE);
    assign accept    = in_valid && in_ready;
    assign handshake = sym_valid && sym_ready;

    // An all-zero group contributes a full 16 zeros to the carried run.
    assign accNext  = acc_q + (in_flag ? ACC_W'(in_left) : ZRL_SPAN);

    // A size of 16 wraps to 0 in four bits, so subtracting one still lands on 15.
    assign firstIdx = in_size[3:0] - 4'd1;
    assign prevIdx  = idx_q - 4'd1;

    // Next-state logic. Entries are walked from idx = size-1 down to 0, and
    // pendRun holds the zeros still owed before the entry at idx.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        pendRun_d = pendRun_q;
        idx_d     = idx_q;
        array_d   = array_q;
        right_d   = right_q;
        last_d    = last_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    array_d = in_array;
                    right_d = in_right;
                    last_d  = in_last;
                    if (in_size == 5'd0) begin
                        acc_d = accNext;
                        if (in_last) begin
                            state_d = EOB;
                        end
                    end else begin
                        idx_d     = firstIdx;
                        pendRun_d = accNext + ACC_W'(entryRun(in_array[32'(firstIdx)*ENTRY_W +: ENTRY_W]));
                        acc_d     = '0;
                        state_d   = EMIT;
                    end
                end
            end

            EMIT: begin
                if (handshake) begin
                    if (pendRun_q >= ZRL_SPAN) begin
                        pendRun_d = pendRun_q - ZRL_SPAN;
                    end else if (idx_q != 4'd0) begin
                        idx_d     = prevIdx;
                        pendRun_d = ACC_W'(entryRun(array_q[32'(prevIdx)*ENTRY_W +: ENTRY_W]));
                    end else if (!last_q) begin
                        // Trailing zeros roll over into the next group.
                        acc_d   = ACC_W'(right_q);
                        state_d = IDLE;
                    end else if (right_q == 4'd0) begin
                        acc_d   = '0;
                        state_d = IDLE;
                    end else begin
                        // Block ends in zeros: those are covered by EOB, never ZRL.
                        state_d = EOB;
                    end
                end
            end

            EOB: begin
                if (handshake) begin
                    acc_d   = '0;
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Symbol decode from the next state, so the outputs come straight from
    // flops. While stalled the next state equals the current one, which keeps
    // every sym_* output steady until the handshake.
    always_comb begin
        symValid_d = 1'b0;
        symRun_d   = '0;
        symLevel_d = '0;
        symZrl_d   = 1'b0;
        symEob_d   = 1'b0;
        symLast_d  = 1'b0;

        case (state_d)
            EMIT: begin
                symValid_d = 1'b1;
                if (pendRun_d >= ZRL_SPAN) begin
                    symZrl_d   = 1'b1;
                    symRun_d   = ZRL_RUN;
                    symLevel_d = ZRL_LEVEL;
                end else begin
                    symRun_d   = pendRun_d[SYM_RUN_W-1:0];
                    symLevel_d = entryLevel(array_d[32'(idx_d)*ENTRY_W +: ENTRY_W]);
                    symLast_d  = (idx_d == 4'd0) && last_d && (right_d == 4'd0);
                end
            end

            EOB: begin
                symValid_d = 1'b1;
                symEob_d   = 1'b1;
                symLast_d  = 1'b1;
                symRun_d   = EOB_RUN;
                symLevel_d = EOB_LEVEL;
            end

            default: begin
                symValid_d = 1'b0;
            end
        endcase
    end

    // Control and datapath registers; reset drops any partial block.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            pendRun_q <= '0;
            idx_q     <= '0;
            array_q   <= '0;
            right_q   <= '0;
            last_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            pendRun_q <= pendRun_d;
            idx_q     <= idx_d;
            array_q   <= array_d;
            right_q   <= right_d;
            last_q    <= last_d;
        end
    end

    // Registered symbol outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sym_valid <= 1'b0;
            sym_run   <= '0;
            sym_level <= '0;
            sym_zrl   <= 1'b0;
            sym_eob   <= 1'b0;
            sym_last  <= 1'b0;
        end else begin
            sym_valid <= symValid_d;
            sym_run   <= symRun_d;
            sym_level <= symLevel_d;
            sym_zrl   <= symZrl_d;
            sym_eob   <= symEob_d;
            sym_last  <= symLast_d;
        end
    end

endmodule
